time_of_day_counter: RTL and testbench

- Free-running 24-hour time-of-day counter with hours, minutes and seconds.
- Produces `minute_counter` and `ore_counter`, which the alarm compare block and the display path consume directly.
- Accepts a synchronous time-set from the UART command path.
- Built from a clock-cycle prescaler followed by a seconds/minutes/hours cascade.

---
 rtl/time_of_day_counter.sv | 85 ++++++++
 tb/tb_time_of_day_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour hh:mm:ss counter driven by a clock-cycle
// prescaler. It supports a synchronous time-set with range checking.
// Every output is a register, so no input reaches an output combinationally.
module time_of_day_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [5:0] minute_setare,
    input  logic [4:0] ore_setare,
    output logic [5:0] secunde_counter,
    output logic [5:0] minute_counter,
    output logic [4:0] ore_counter,
    output logic       tick_sec,
    output logic       tick_minut,
    output logic       load_err
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]         SEC_MAX   = 6'd59;
    localparam logic [5:0]         MIN_MAX   = 6'd59;
    localparam logic [4:0]         HOUR_MAX  = 5'd23;

    logic [PRESC_W-1:0] presc;
    logic               load_ok;
    logic               sec_event;

    // A time-set is accepted only when both fields are within range.
    assign load_ok   = (minute_setare <= MIN_MAX) && (ore_setare <= HOUR_MAX);
    // A second event is the last prescaler cycle of a running second.
    assign sec_event = enable && (presc == PRESC_MAX);

    // Prescaler and cascade. Priority is reset, then a valid load, then counting.
    // An invalid load does not disturb counting and only raises load_err.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc           <= '0;
            secunde_counter <= '0;
            minute_counter  <= '0;
            ore_counter     <= '0;
            tick_sec        <= 1'b0;
            tick_minut      <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            tick_sec   <= 1'b0;
            tick_minut <= 1'b0;
            load_err   <= 1'b0;
            if (load && load_ok) begin
                // A valid load discards the partial second and any coincident event.
                presc           <= '0;
                secunde_counter <= '0;
                minute_counter  <= minute_setare;
                ore_counter     <= ore_setare;
            end else begin
                load_err <= load;
                if (sec_event) begin
                    presc    <= '0;
                    tick_sec <= 1'b1;
                    if (secunde_counter < SEC_MAX) begin
                        secunde_counter <= secunde_counter + 6'd1;
                    end else begin
                        secunde_counter <= '0;
                        tick_minut      <= 1'b1;
                        if (minute_counter < MIN_MAX) begin
                            minute_counter <= minute_counter + 6'd1;
                        end else begin
                            minute_counter <= '0;
                            if (ore_counter < HOUR_MAX) begin
                                ore_counter <= ore_counter + 5'd1;
                            end else begin
                                ore_counter <= '0;
                            end
                        end
                    end
                end else if (enable) begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter. The reference model holds the time as total
// seconds of the day and derives hh:mm:ss from it arithmetically. The bench
// runs the directed scenarios first and then a randomized run.
module tb_time_of_day_counter;

    localparam int TPS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       load = 1'b0;
    logic [5:0] minute_setare = '0;
    logic [4:0] ore_setare = '0;
    logic [5:0] secunde_counter;
    logic [5:0] minute_counter;
    logic [4:0] ore_counter;
    logic       tick_sec;
    logic       tick_minut;
    logic       load_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    int m_tod   = 0;
    int m_presc = 0;
    bit m_ts = 0, m_tm = 0, m_le = 0;

    time_of_day_counter #(.TICKS_PER_SEC(TPS), .PRESC_W(3)) dut (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .minute_setare(minute_setare), .ore_setare(ore_setare),
        .secunde_counter(secunde_counter), .minute_counter(minute_counter),
        .ore_counter(ore_counter), .tick_sec(tick_sec),
        .tick_minut(tick_minut), .load_err(load_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        m_ts = 0; m_tm = 0; m_le = 0;
        if (reset) begin
            m_tod = 0; m_presc = 0;
        end else if (load && minute_setare <= 59 && ore_setare <= 23) begin
            m_tod = int'(ore_setare) * 3600 + int'(minute_setare) * 60;
            m_presc = 0;
        end else begin
            m_le = load;
            if (enable) begin
                if (m_presc == TPS - 1) begin
                    m_presc = 0;
                    m_tod = (m_tod + 1) % 86400;
                    m_ts = 1;
                    m_tm = (m_tod % 60 == 0);
                end else begin
                    m_presc++;
                end
            end
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("sec",     32'(secunde_counter), 32'(m_tod % 60));
        chk("min",     32'(minute_counter),  32'((m_tod / 60) % 60));
        chk("hour",    32'(ore_counter),     32'(m_tod / 3600));
        chk("tick_s",  32'(tick_sec),        32'(m_ts));
        chk("tick_m",  32'(tick_minut),      32'(m_tm));
        chk("lerr",    32'(load_err),        32'(m_le));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input int hh, input int mm);
        load = 1'b1; ore_setare = 5'(hh); minute_setare = 6'(mm);
        cycle();
        load = 1'b0;
    endtask

    initial begin
        // Reset for two cycles, then run.
        cycles(2);
        chk("rst_sec", 32'(secunde_counter), 32'd0);
        chk("rst_tick", 32'(tick_sec), 32'd0);
        reset = 1'b0;
        cycles(3);
        chk("no_early_tick", 32'(tick_sec), 32'd0);
        cycle();
        chk("first_tick", 32'(tick_sec), 32'd1);
        chk("first_sec", 32'(secunde_counter), 32'd1);
        cycles(236);
        chk("min1_tick", 32'(tick_minut), 32'd1);
        chk("min1_val", 32'(minute_counter), 32'd1);

        // Midnight wrap from 23:59.
        do_load(23, 59);
        cycles(240);
        chk("wrap_h", 32'(ore_counter), 32'd0);
        chk("wrap_m", 32'(minute_counter), 32'd0);
        chk("wrap_s", 32'(secunde_counter), 32'd0);
        chk("wrap_tm", 32'(tick_minut), 32'd1);

        // Load mid-second: the partial second is discarded.
        cycles(2);
        do_load(12, 34);
        chk("ld_h", 32'(ore_counter), 32'd12);
        chk("ld_m", 32'(minute_counter), 32'd34);
        chk("ld_s", 32'(secunde_counter), 32'd0);
        chk("ld_ts", 32'(tick_sec), 32'd0);
        cycles(3);
        chk("ld_no_tick", 32'(tick_sec), 32'd0);
        cycle();
        chk("ld_tick", 32'(tick_sec), 32'd1);

        // Invalid loads. The first one coincides with a second event.
        cycles(3);
        do_load(24, 10);
        chk("bad_h_err", 32'(load_err), 32'd1);
        chk("bad_h_ts", 32'(tick_sec), 32'd1);
        chk("bad_h_sec", 32'(secunde_counter), 32'd2);
        cycle();
        do_load(5, 60);
        chk("bad_m_err", 32'(load_err), 32'd1);
        chk("bad_m_h", 32'(ore_counter), 32'd12);

        // Freeze at 07:15:30 with presc=1.
        do_load(7, 15);
        cycles(121);
        enable = 1'b0;
        cycles(100);
        chk("frz_s", 32'(secunde_counter), 32'd30);
        chk("frz_m", 32'(minute_counter), 32'd15);
        enable = 1'b1;
        cycles(2);
        chk("res_no_tick", 32'(tick_sec), 32'd0);
        cycle();
        chk("res_tick", 32'(tick_sec), 32'd1);
        chk("res_sec", 32'(secunde_counter), 32'd31);

        // Reset wins over a simultaneous load.
        do_load(5, 10);
        cycles(80);
        chk("pre_rst_s", 32'(secunde_counter), 32'd20);
        reset = 1'b1; load = 1'b1; ore_setare = 5'd9; minute_setare = 6'd0;
        cycle();
        chk("rl_h", 32'(ore_counter), 32'd0);
        chk("rl_err", 32'(load_err), 32'd0);
        chk("rl_ts", 32'(tick_sec), 32'd0);
        reset = 1'b0; load = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 39) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            ore_setare    = 5'($urandom_range(0, 31));
            minute_setare = 6'($urandom_range(0, 63));
            if (load && $urandom_range(0, 1) == 1) begin
                ore_setare = 5'($urandom_range(22, 23));
                minute_setare = 6'($urandom_range(58, 59));
            end
            cycle();
        end
        reset = 1'b0; load = 1'b0; enable = 1'b1;
        cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
